mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Upstream sequencer for the 4K x 16 unified memory. Accepts one load/store request at a time from the CPU over a valid/ready handshake.
//  Drives the memory's address, data_in, Read and Write pins, and returns read data or a fault over a second valid/ready channel.
//  Enforces instruction-region write protection before a Write ever reaches memory.
// PARAMETERS
//  ADDR_W       12      memory address width (4096 words)
//  DATA_W       16      memory word width
//  WAIT_CYCLES  0       extra ACCESS cycles per transaction (0..15), models slow memory
//  INSTR_TOP    12'h7FF highest protected (instruction) address; region 0..INSTR_TOP is write-protected
// PORTS
//  clock         in   1       single clock, all state on rising edge
//  reset         in   1       asynchronous, active-low; low forces reset state immediately
//  req_valid     in   1       CPU request present
//  req_ready     out  1       controller can accept (high only in IDLE)
//  req_write     in   1       1 = store, 0 = load
//  req_addr      in   ADDR_W  word address
//  req_wdata     in   DATA_W  store data
//  rsp_valid     out  1       response present
//  rsp_ready     in   1       CPU takes response
//  rsp_rdata     out  DATA_W  load data (0 for stores and faults)
//  rsp_fault     out  1       request rejected (protected write)
//  mem_address   out  ADDR_W  to memory address
//  mem_data_in   out  DATA_W  to memory data_in
//  mem_read      out  1       to memory Read (memory read is combinational)
//  mem_write     out  1       to memory Write (memory write commits on rising edge)
//  mem_data_out  in   DATA_W  from memory data_out
// BEHAVIOUR
//  - Reset (reset=0): state=IDLE, wait count=0; every output reg 0 (rsp_*, mem_*); req_ready=1 once reset is released.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE. Faulted requests go IDLE -> RESP directly.
//  - IDLE: req_ready=1. When req_valid&req_ready at an edge, latch write/addr/wdata.
//    - Fault = req_write && req_addr <= INSTR_TOP (this includes address 0).
//    - Fault: rsp_fault=1, rsp_rdata=0 -> RESP. Otherwise -> ACCESS with wait count = WAIT_CYCLES.
//  - ACCESS: lasts WAIT_CYCLES+1 cycles.
//    - mem_address/mem_data_in hold the latched values throughout.
//    - Load: mem_read=1 for every ACCESS cycle. rsp_rdata <= mem_data_out at the edge ending the last cycle.
//    - Store: mem_write=1 only in the last ACCESS cycle (exactly one commit edge); rsp_rdata=0.
//    - mem_read and mem_write are never high together. Both are 0 outside ACCESS.
//  - RESP: rsp_valid=1. rsp_rdata and rsp_fault are stable until rsp_valid&rsp_ready, then -> IDLE and rsp_* clear.
//  - Latency: accept edge T -> rsp_valid high in cycle T+2+WAIT_CYCLES (fault: T+1). Minimum turnaround = 3+WAIT_CYCLES cycles.
//  - Backpressure: while in ACCESS or RESP, req_ready=0; no request is lost or double-accepted.
//  - mem_address and mem_data_in are 0 in IDLE. Memory's Read=0 path then returns its internal register, which is ignored.
//  - Reset mid-ACCESS: mem_write and mem_read drop asynchronously. A partially waited store does not commit.
//    A store that already got its commit edge stays committed. No response is issued.
// CONFIGURATION
//  MAC_FAULT_CNT_EN defined: adds output fault_count [7:0].
//    - Increments on each faulted accept; saturates at 8'hFF. Cleared by reset only.
//  MAC_FAULT_CNT_EN undefined: no port, no logic; faults are reported only via rsp_fault.
// STRUCTURE
//  Package mem_access_pkg:
//    - typedef mac_state_t {IDLE, ACCESS, RESP}
//    - ADDR_W/DATA_W defaults
//    - INSTR_TOP constant
//    - function is_protected(addr, write)
//  One natural sub-module: mac_wait_timer (4-bit load/decrement counter, 'last' output). FSM and datapath regs stay in top.
// TESTING
//  1 Preload mem[0x800]=0x1234, WAIT_CYCLES=0, load 0x800:
//    -> mem_read high 1 cycle with mem_address=0x800; rsp_valid at accept+2; rdata=0x1234; fault=0.
//  2 Store 0xABCD to 0x900, then load 0x900:
//    -> mem_write high exactly 1 cycle; load returns 0xABCD, fault=0.
//  3 Store to 0x7FF, 0x000 and 0x123:
//    -> mem_write never asserts; each rsp fault=1, rdata=0; a later load of 0x7FF returns its original value.
//    -> With MAC_FAULT_CNT_EN, 300 faulted stores give fault_count=0xFF.
//  4 Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1:
//    -> rsp_valid/rdata stable, req_ready=0, second request accepted only after the response handshake.
//  5 WAIT_CYCLES=3, load 0xFFF:
//    -> mem_read high 4 consecutive cycles; rsp_valid at accept+5 with mem[0xFFF].
//  6 Pull reset low in the 2nd ACCESS cycle of a WAIT_CYCLES=3 store to 0xA00:
//    -> mem_write/mem_read/rsp_* go 0 without a clock edge; mem[0xA00] unchanged; req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types, default widths and the write-protection rule
// for the unified-memory access controller.
package mem_access_pkg;

    localparam int          ADDR_W_DEF    = 12;
    localparam int          DATA_W_DEF    = 16;
    localparam logic [11:0] INSTR_TOP_DEF = 12'h7FF;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} mac_state_t;

    function automatic logic is_protected(input logic [31:0] addr, input logic write,
                                          input logic [31:0] top);
        return write && (addr <= top);
    endfunction

endpackage

// File: rtl/mac_wait_timer.sv
// mac_wait_timer: 4-bit load/decrement counter; o_last flags the final ACCESS cycle.
module mac_wait_timer (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [3:0] i_value,
    input  logic       i_en,
    output logic       o_last
);

    logic [3:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_load)
            r_count <= i_value;
        else if (i_en && r_count != 4'd0)
            r_count <= r_count - 4'd1;
    end

    assign o_last = (r_count == 4'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time load/store sequencer for the 4K x 16 memory with
// instruction-region write protection. Define MAC_FAULT_CNT_EN to add o_fault_count.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [ADDR_W-1:0] INSTR_TOP   = ADDR_W'(INSTR_TOP_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_fault,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data_in,
    output logic              o_mem_read,
    output logic              o_mem_write,
`ifdef MAC_FAULT_CNT_EN
    output logic [7:0]        o_fault_count,
`endif
    input  logic [DATA_W-1:0] i_mem_data_out
);

    mac_state_t        r_state, w_next;
    logic              r_write, r_rsp_fault;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rsp_rdata;
    logic              w_accept, w_fault, w_last, w_in_access, w_rsp_done;

    assign w_accept    = (r_state == IDLE) && i_req_valid;
    assign w_fault     = is_protected(32'(i_req_addr), i_req_write, 32'(INSTR_TOP));
    assign w_in_access = (r_state == ACCESS);
    assign w_rsp_done  = (r_state == RESP) && i_rsp_ready;

    mac_wait_timer u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_accept),
        .i_value (4'(WAIT_CYCLES)),
        .i_en    (w_in_access),
        .o_last  (w_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_fault ? RESP : ACCESS;
            ACCESS:  if (w_last) w_next = RESP;
            RESP:    if (i_rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write     <= i_req_write;
                r_addr      <= i_req_addr;
                r_wdata     <= i_req_wdata;
                r_rsp_rdata <= '0;
                r_rsp_fault <= w_fault;
            end
            if (w_in_access && w_last)
                r_rsp_rdata <= r_write ? '0 : i_mem_data_out;
            if (w_rsp_done) begin
                r_rsp_rdata <= '0;
                r_rsp_fault <= 1'b0;
            end
        end
    end

    // Memory strobes decode from state so an async reset drops them without a clock edge.
    assign o_req_ready   = (r_state == IDLE);
    assign o_rsp_valid   = (r_state == RESP);
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_fault   = r_rsp_fault;
    assign o_mem_address = w_in_access ? r_addr : '0;
    assign o_mem_data_in = w_in_access ? r_wdata : '0;
    assign o_mem_read    = w_in_access && !r_write;
    assign o_mem_write   = w_in_access && r_write && w_last;

`ifdef MAC_FAULT_CNT_EN
    logic [7:0] r_fault_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_fault_count <= '0;
        else if (w_accept && w_fault && r_fault_count != 8'hFF)
            r_fault_count <= r_fault_count + 8'd1;
    end

    assign o_fault_count = r_fault_count;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl; instance 0 has WAIT_CYCLES=0,
// instance 1 has WAIT_CYCLES=3, each with its own behavioural 4K x 16 memory.
module tb_mem_access_ctrl;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = '0, req_ready, req_write = '0, rsp_valid, rsp_ready = '0;
    logic [1:0]       rsp_fault, mem_read, mem_write, bd_we = '0;
    logic [1:0][11:0] req_addr = '0, mem_address;
    logic [1:0][15:0] req_wdata = '0, rsp_rdata, mem_data_in, mem_data_out;
    logic [11:0]      bd_a = '0;
    logic [15:0]      bd_d = '0;
`ifdef MAC_FAULT_CNT_EN
    logic [1:0][7:0]  fault_count;
`endif
    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] mem [4096];
        always @(posedge clk) begin
            if (bd_we[g])
                mem[bd_a] <= bd_d;
            else if (mem_write[g])
                mem[mem_address[g]] <= mem_data_in[g];
        end
        assign mem_data_out[g] = mem[mem_address[g]];
        mem_access_ctrl #(.WAIT_CYCLES(g * 3)) u_dut (
            .i_clk          (clk),
            .i_rst_n        (rst_n),
            .i_req_valid    (req_valid[g]),
            .o_req_ready    (req_ready[g]),
            .i_req_write    (req_write[g]),
            .i_req_addr     (req_addr[g]),
            .i_req_wdata    (req_wdata[g]),
            .o_rsp_valid    (rsp_valid[g]),
            .i_rsp_ready    (rsp_ready[g]),
            .o_rsp_rdata    (rsp_rdata[g]),
            .o_rsp_fault    (rsp_fault[g]),
            .o_mem_address  (mem_address[g]),
            .o_mem_data_in  (mem_data_in[g]),
            .o_mem_read     (mem_read[g]),
            .o_mem_write    (mem_write[g]),
`ifdef MAC_FAULT_CNT_EN
            .o_fault_count  (fault_count[g]),
`endif
            .i_mem_data_out (mem_data_out[g])
        );
    end

    task automatic bd_write(input int i, input logic [11:0] a, input logic [15:0] d);
        bd_a = a;
        bd_d = d;
        bd_we[i] = 1'b1;
        @(posedge clk);
        #1 bd_we[i] = 1'b0;
    endtask

    // Drives one request; lat = edges from the accept edge until rsp_valid is seen.
    task automatic xfer(input int i, input logic w, input logic [11:0] a, input logic [15:0] d,
                        output int lat, output int rd, output int wr, output logic ok,
                        output logic [15:0] rdata, output logic flt);
        int guard = 0;
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_valid[i] = 1'b1;
        @(negedge clk);
        while (!req_ready[i] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        lat = 0; rd = 0; wr = 0; ok = 1'b1;
        @(negedge clk);
        while (!rsp_valid[i] && lat < 40) begin
            rd += int'(mem_read[i]);
            wr += int'(mem_write[i]);
            if (mem_address[i] !== a || (w && mem_data_in[i] !== d) || (mem_read[i] && mem_write[i]))
                ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata[i];
        flt   = rsp_fault[i];
        rsp_ready[i] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[i] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if ({rsp_valid[i], rsp_fault[i], rsp_rdata[i], mem_read[i], mem_write[i],
                 mem_address[i], mem_data_in[i]} !== '0)
                $display("FAIL reset_outputs[%0d]: valid=%b fault=%b rdata=%h rd=%b wr=%b addr=%h din=%h, want all 0",
                         i, rsp_valid[i], rsp_fault[i], rsp_rdata[i], mem_read[i], mem_write[i],
                         mem_address[i], mem_data_in[i]);
            else n_pass++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (req_ready !== 2'b11) $display("FAIL reset_ready: got %b want 11", req_ready);
        else n_pass++;
    endtask

    task automatic test_load();
        int lat, rd, wr; logic ok, flt; logic [15:0] rdata;
        bd_write(0, 12'h800, 16'h1234);
        xfer(0, 1'b0, 12'h800, 16'h0000, lat, rd, wr, ok, rdata, flt);
        n_total++;
        if ({lat, rd, wr} !== {32'd1, 32'd1, 32'd0})
            $display("FAIL load_timing: lat=%0d reads=%0d writes=%0d want 1/1/0", lat, rd, wr);
        else n_pass++;
        n_total++;
        if (ok !== 1'b1) $display("FAIL load_addr: got %b want 1", ok);
        else n_pass++;
        n_total++;
        if ({rdata, flt} !== {16'h1234, 1'b0})
            $display("FAIL load_data: rdata=%h fault=%b want 1234/0", rdata, flt);
        else n_pass++;
    endtask

    task automatic test_store_load();
        int lat, rd, wr; logic ok, flt; logic [15:0] rdata;
        xfer(0, 1'b1, 12'h900, 16'hABCD, lat, rd, wr, ok, rdata, flt);
        n_total++;
        if ({lat, rd, wr, ok} !== {32'd1, 32'd0, 32'd1, 1'b1})
            $display("FAIL store_strobe: lat=%0d reads=%0d writes=%0d ok=%b want 1/0/1/1", lat, rd, wr, ok);
        else n_pass++;
        n_total++;
        if ({rdata, flt} !== {16'h0000, 1'b0})
            $display("FAIL store_rsp: rdata=%h fault=%b want 0000/0", rdata, flt);
        else n_pass++;
        xfer(0, 1'b0, 12'h900, 16'h0000, lat, rd, wr, ok, rdata, flt);
        n_total++;
        if ({rdata, flt} !== {16'hABCD, 1'b0})
            $display("FAIL store_readback: rdata=%h fault=%b want abcd/0", rdata, flt);
        else n_pass++;
    endtask

    task automatic test_protect();
        int lat, rd, wr; logic ok, flt; logic [15:0] rdata;
        logic [11:0] addrs [3] = '{12'h7FF, 12'h000, 12'h123};
        bd_write(0, 12'h7FF, 16'h5A5A);
        foreach (addrs[k]) begin
            xfer(0, 1'b1, addrs[k], 16'hDEAD, lat, rd, wr, ok, rdata, flt);
            n_total++;
            if ({lat, wr, rdata, flt} !== {32'd0, 32'd0, 16'h0000, 1'b1})
                $display("FAIL protect_%h: lat=%0d writes=%0d rdata=%h fault=%b want 0/0/0000/1",
                         addrs[k], lat, wr, rdata, flt);
            else n_pass++;
        end
        xfer(0, 1'b0, 12'h7FF, 16'h0000, lat, rd, wr, ok, rdata, flt);
        n_total++;
        if ({rdata, flt} !== {16'h5A5A, 1'b0})
            $display("FAIL protect_intact: rdata=%h fault=%b want 5a5a/0", rdata, flt);
        else n_pass++;
        xfer(0, 1'b1, 12'h800, 16'h1111, lat, rd, wr, ok, rdata, flt);
        n_total++;
        if ({wr, flt} !== {32'd1, 1'b0})
            $display("FAIL protect_boundary_800: writes=%0d fault=%b want 1/0", wr, flt);
        else n_pass++;
`ifdef MAC_FAULT_CNT_EN
        for (int k = 0; k < 300; k++)
            xfer(0, 1'b1, 12'h010, 16'h0000, lat, rd, wr, ok, rdata, flt);
        n_total++;
        if (fault_count[0] !== 8'hFF) $display("FAIL fault_count: got %h want ff", fault_count[0]);
        else n_pass++;
`endif
    endtask

    task automatic test_backpressure();
        int n = 0;
        req_write[0] = 1'b0;
        req_addr[0]  = 12'h900;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_addr[0] = 12'h800;
        while (!rsp_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_total++;
            if ({rsp_valid[0], rsp_rdata[0], req_ready[0], mem_read[0]} !== {1'b1, 16'hABCD, 1'b0, 1'b0})
                $display("FAIL backpressure_hold%0d: valid=%b rdata=%h ready=%b rd=%b want 1/abcd/0/0",
                         c, rsp_valid[0], rsp_rdata[0], req_ready[0], mem_read[0]);
            else n_pass++;
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0;
        @(negedge clk);
        n_total++;
        if ({req_ready[0], rsp_valid[0], rsp_rdata[0]} !== {1'b1, 1'b0, 16'h0000})
            $display("FAIL backpressure_release: ready=%b valid=%b rdata=%h want 1/0/0000",
                     req_ready[0], rsp_valid[0], rsp_rdata[0]);
        else n_pass++;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if ({rsp_valid[0], rsp_rdata[0]} !== {1'b1, 16'h1111})
            $display("FAIL backpressure_second: valid=%b rdata=%h want 1/1111", rsp_valid[0], rsp_rdata[0]);
        else n_pass++;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({rsp_valid[0], mem_read[0], req_ready[0]} !== 3'b001)
            $display("FAIL backpressure_single: valid=%b rd=%b ready=%b want 0/0/1",
                     rsp_valid[0], mem_read[0], req_ready[0]);
        else n_pass++;
    endtask

    task automatic test_wait();
        int lat, rd, wr; logic ok, flt; logic [15:0] rdata;
        bd_write(1, 12'hFFF, 16'hBEEF);
        xfer(1, 1'b0, 12'hFFF, 16'h0000, lat, rd, wr, ok, rdata, flt);
        n_total++;
        if ({lat, rd, wr, ok} !== {32'd4, 32'd4, 32'd0, 1'b1})
            $display("FAIL wait_load_timing: lat=%0d reads=%0d writes=%0d ok=%b want 4/4/0/1", lat, rd, wr, ok);
        else n_pass++;
        n_total++;
        if ({rdata, flt} !== {16'hBEEF, 1'b0})
            $display("FAIL wait_load_data: rdata=%h fault=%b want beef/0", rdata, flt);
        else n_pass++;
        xfer(1, 1'b1, 12'hB00, 16'h4321, lat, rd, wr, ok, rdata, flt);
        n_total++;
        if ({lat, rd, wr, ok} !== {32'd4, 32'd0, 32'd1, 1'b1})
            $display("FAIL wait_store_timing: lat=%0d reads=%0d writes=%0d ok=%b want 4/0/1/1", lat, rd, wr, ok);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic quiet = 1'b1;
        bd_write(1, 12'hA00, 16'h0F0F);
        req_write[1] = 1'b1;
        req_addr[1]  = 12'hA00;
        req_wdata[1] = 16'h1234;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if ({mem_address[1], mem_write[1]} !== {12'hA00, 1'b0})
            $display("FAIL reset_mid_pre: addr=%h wr=%b want a00/0", mem_address[1], mem_write[1]);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({mem_write[1], mem_read[1], rsp_valid[1], rsp_fault[1], rsp_rdata[1], mem_address[1]} !== '0)
            $display("FAIL reset_mid_async: wr=%b rd=%b valid=%b fault=%b rdata=%h addr=%h want all 0",
                     mem_write[1], mem_read[1], rsp_valid[1], rsp_fault[1], rsp_rdata[1], mem_address[1]);
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid[1] || mem_write[1] || !req_ready[1]) quiet = 1'b0;
        end
        n_total++;
        if (quiet !== 1'b1) $display("FAIL reset_mid_quiet: got %b want 1", quiet);
        else n_pass++;
        n_total++;
        if (g_dut[1].mem[12'hA00] !== 16'h0F0F)
            $display("FAIL reset_mid_mem: got %h want 0f0f", g_dut[1].mem[12'hA00]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_load();
        test_protect();
        test_backpressure();
        test_wait();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
